blink_monitor: RTL and testbench
================================

// Module: blink_monitor
// PURPOSE
//   Receive-side checker for the LED blink output: samples an asynchronous blink
//   line (e.g. ledpin from blink), measures rise-to-rise period and high time in
//   clk cycles, and validates period against an expected value +/- tolerance.
//   Reports lock after consecutive good periods; flags a stuck line on timeout.
// PARAMETERS
//   CNT_W       28          width of period/high-time counters and outputs
//   EXP_PERIOD  50_000_000  expected rise-to-rise period, clk cycles
//   TOL         500_000     allowed |period - EXP_PERIOD|, inclusive
//   LOCK_COUNT  4           consecutive good periods required to lock
//   TIMEOUT     100_000_000 cycles without a rise before stuck is declared
//   Constraints: TOL <= EXP_PERIOD; EXP_PERIOD+TOL < TIMEOUT < 2**CNT_W; LOCK_COUNT >= 1
// PORTS
//   clk           in   1      system clock
//   rst           in   1      asynchronous, active-high reset
//   ledpin        in   1      monitored blink line, asynchronous to clk
//   period        out  CNT_W  last measured rise-to-rise period, cycles
//   high_time     out  CNT_W  cycles line was high within that period
//   period_valid  out  1      1-cycle pulse: period/high_time updated
//   period_err    out  1      1-cycle pulse with period_valid: period out of tolerance
//   locked        out  1      level: LOCK_COUNT consecutive good periods seen
//   stuck         out  1      level: no rising edge for TIMEOUT cycles
//   stuck_level   out  1      synchronized line value while stuck (0 otherwise)
// BEHAVIOUR
//   - Reset (async, immediate): all outputs 0, sync regs 0, counters 0, state IDLE.
//   - Sync: ledpin -> s1 -> s2 (2-FF); s3 <= s2; rise = s2 & ~s3. Only rises matter.
//     Outputs update on the 3rd clk edge after the first edge sampling ledpin=1.
//   - Counters (all states): on rise cycle period_cnt<=1, high_cnt<=1; else
//     period_cnt+=1 and high_cnt+=s2, both saturating at 2**CNT_W-1.
//   - good = (EXP_PERIOD-TOL <= period_cnt <= EXP_PERIOD+TOL), evaluated on rise.
//   - FSM states IDLE, MEASURE, LOCKED, STUCK:
//     IDLE: rise -> MEASURE, good_cnt<=0; no period_valid (no reference edge).
//     MEASURE: rise -> period<=period_cnt, high_time<=high_cnt, period_valid=1;
//       good: good_cnt+=1; if new good_cnt==LOCK_COUNT -> LOCKED.
//       bad: good_cnt<=0, period_err=1, stay MEASURE.
//     LOCKED: rise+good -> stay; rise+bad -> period_err=1, good_cnt<=0, MEASURE.
//     MEASURE/LOCKED: no rise and period_cnt==TIMEOUT -> STUCK, good_cnt<=0.
//     STUCK: rise -> MEASURE as first edge (no period_valid); clears stuck.
//   - locked = (state==LOCKED), registered, changes on same edge as period_valid.
//   - stuck = (state==STUCK); stuck_level = s2 while STUCK, else 0.
//   - IDLE never times out (stuck stays 0 until a first rise is seen).
//   - Rise and timeout in same cycle: rise wins, no STUCK entry.
//   - period_err never asserts without period_valid; pulses last exactly 1 cycle.
//   - period/high_time hold last values until next period_valid (also across STUCK).
// TESTING (bench params: CNT_W=8, EXP_PERIOD=20, TOL=2, LOCK_COUNT=3, TIMEOUT=50;
//          clk period 20 ns, ledpin driven as square wave)
//   1. Reset, 20-cycle wave, 10 high -> 1st rise no pulse; each later rise:
//      period_valid, period=20, high_time=10, period_err=0; locked=1 with 4th rise.
//   2. Locked, one 25-cycle period -> period_valid+period_err, period=25, locked->0
//      same edge; then 20-cycle periods -> locked again after 3 good ones.
//   3. Tolerance edges: periods 18 and 22 -> period_err=0; 17 and 23 -> period_err=1.
//   4. Hold ledpin low 60 cycles after lock -> stuck=1 when period_cnt hits 50,
//      stuck_level=0, locked=0; hold high instead -> stuck_level=1; next rise
//      clears stuck with no period_valid; following rise gives period_valid.
//   5. Assert rst between clk edges while locked -> all outputs 0 immediately;
//      after release first rise gives no pulse, second rise period_valid=1.
//   6. Hold low >255 cycles from reset (IDLE) -> stuck stays 0, no pulses; then
//      a glitch-free 20-cycle wave locks normally.

Source files
------------

// File: rtl/blink_monitor.sv
// blink_monitor: receive-side checker for an asynchronous blink line.
// The line is synchronized, rising edges are detected, and the module measures
// the rise-to-rise period and the high time in clk cycles. Each period is
// checked against EXP_PERIOD +/- TOL. The block reports lock after LOCK_COUNT
// consecutive good periods. It flags a stuck line when no rise arrives for
// TIMEOUT cycles.
module blink_monitor #(
    parameter int unsigned CNT_W      = 28,
    parameter int unsigned EXP_PERIOD = 50_000_000,
    parameter int unsigned TOL        = 500_000,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TIMEOUT    = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ledpin,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             period_err,
    output logic             locked,
    output logic             stuck,
    output logic             stuck_level
);

    localparam int unsigned      GC_W     = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PER_LO   = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] PER_HI   = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [GC_W-1:0]  GC_LOCK  = GC_W'(LOCK_COUNT);
    localparam logic [GC_W-1:0]  GC_ONE   = GC_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED,
        STUCK
    } state_t;

    // synchronizer and edge-detect stage
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // free-running measurement counters
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;

    // FSM state and consecutive-good counter
    state_t           state_q, state_d;
    logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
    logic [GC_W-1:0]  good_inc;

    // registered results
    logic [CNT_W-1:0] period_q,       period_d;
    logic [CNT_W-1:0] high_time_q,    high_time_d;
    logic             period_valid_q, period_valid_d;
    logic             period_err_q,   period_err_d;

    logic rise;
    logic good;
    logic timeout;

    assign rise    = s2_q & ~s3_q;
    assign good    = (period_cnt_q >= PER_LO) && (period_cnt_q <= PER_HI);
    assign timeout = (period_cnt_q == TMO_CNT);
    assign good_inc = good_cnt_q + GC_ONE;

    // Register all state; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            period_cnt_q   <= '0;
            high_cnt_q     <= '0;
            state_q        <= IDLE;
            good_cnt_q     <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            period_err_q   <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            period_cnt_q   <= period_cnt_d;
            high_cnt_q     <= high_cnt_d;
            state_q        <= state_d;
            good_cnt_q     <= good_cnt_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            period_valid_q <= period_valid_d;
            period_err_q   <= period_err_d;
        end
    end

    // Two-flop synchronizer plus one delay stage for rising-edge detection.
    always_comb begin
        s1_d = ledpin;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Period and high-time counters restart on every rise and saturate otherwise.
    always_comb begin
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        if (rise) begin
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
        end else begin
            if (period_cnt_q != CNT_MAX) begin
                period_cnt_d = period_cnt_q + CNT_ONE;
            end
            if (s2_q && (high_cnt_q != CNT_MAX)) begin
                high_cnt_d = high_cnt_q + CNT_ONE;
            end
        end
    end

    // Next-state logic: a rise always takes priority over a timeout.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = MEASURE;
                    good_cnt_d = '0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (good) begin
                        good_cnt_d = good_inc;
                        if (good_inc == GC_LOCK) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end else if (timeout) begin
                    state_d    = STUCK;
                    good_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (!good) begin
                        state_d    = MEASURE;
                        good_cnt_d = '0;
                    end
                end else if (timeout) begin
                    state_d    = STUCK;
                    good_cnt_d = '0;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d    = MEASURE;
                    good_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                good_cnt_d = '0;
            end
        endcase
    end

    // Output logic: publish a measurement only when a reference edge exists.
    always_comb begin
        period_valid_d = rise && ((state_q == MEASURE) || (state_q == LOCKED));
        period_err_d   = period_valid_d && !good;
        period_d       = period_q;
        high_time_d    = high_time_q;
        if (period_valid_d) begin
            period_d    = period_cnt_q;
            high_time_d = high_cnt_q;
        end
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = period_valid_q;
    assign period_err   = period_err_q;
    assign locked       = (state_q == LOCKED);
    assign stuck        = (state_q == STUCK);
    assign stuck_level  = (state_q == STUCK) & s2_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Testbench for blink_monitor: drives square waves on ledpin, predicts each
// period_valid pulse from the driven wave shape, and compares in a monitor.
module tb_blink_monitor;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned EXP_PERIOD = 20;
    localparam int unsigned TOL        = 2;
    localparam int unsigned LOCK_COUNT = 3;
    localparam int unsigned TIMEOUT    = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             ledpin;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             period_err;
    logic             locked;
    logic             stuck;
    logic             stuck_level;

    blink_monitor #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ledpin       (ledpin),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .period_err   (period_err),
        .locked       (locked),
        .stuck        (stuck),
        .stuck_level  (stuck_level)
    );

    always #10 clk = ~clk;

    typedef struct {
        int unsigned per;
        int unsigned hi;
        bit          err;
        bit          lck;
    } exp_t;

    exp_t sb[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // model of the monitor at the level of whole periods
    bit          m_have_ref = 1'b0;
    int unsigned m_len      = 0;
    int unsigned m_h        = 0;
    int unsigned m_good     = 0;
    bit          m_locked   = 1'b0;

    bit prev_pv = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have_ref = 1'b0;
        m_len      = 0;
        m_h        = 0;
        m_good     = 0;
        m_locked   = 1'b0;
        sb.delete();
    endtask

    // Predict the outcome of the rise about to be driven.
    task automatic model_rise(input int unsigned h, input int unsigned l);
        exp_t e;
        bit   g;
        if (m_have_ref) begin
            if (m_len > TIMEOUT) begin
                m_good   = 0;
                m_locked = 1'b0;
            end else begin
                g = (m_len >= EXP_PERIOD - TOL) && (m_len <= EXP_PERIOD + TOL);
                if (g) begin
                    if (!m_locked) begin
                        m_good++;
                        if (m_good == LOCK_COUNT) m_locked = 1'b1;
                    end
                end else begin
                    m_good   = 0;
                    m_locked = 1'b0;
                end
                e.per = m_len;
                e.hi  = m_h;
                e.err = !g;
                e.lck = m_locked;
                sb.push_back(e);
            end
        end
        m_have_ref = 1'b1;
        m_len      = h + l;
        m_h        = h;
    endtask

    // One wave: h cycles high then l cycles low. Called right after a negedge.
    // chk_at != 0 probes the stuck flag just before and just after the timeout.
    task automatic drive_wave(input int unsigned h, input int unsigned l,
                              input int unsigned chk_at, input logic exp_level);
        model_rise(h, l);
        for (int unsigned i = 0; i < h + l; i++) begin
            ledpin = (i < h);
            @(negedge clk);
            if (i + 1 == 3) check("stuck_after_rise", stuck, 0);
            if (chk_at != 0 && i + 1 == chk_at) begin
                check("stuck_before_tmo", stuck, 0);
                check("level_before_tmo", stuck_level, 0);
            end
            if (chk_at != 0 && i + 1 == chk_at + 1) begin
                check("stuck_at_tmo", stuck, 1);
                check("level_at_tmo", stuck_level, exp_level);
                check("locked_at_tmo", locked, 0);
            end
        end
    endtask

    // Monitor: every period_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_pv = 1'b0;
        end else begin
            if (period_err && !period_valid) check("err_without_valid", 1, 0);
            if (period_valid && prev_pv) check("pv_width", 1, 0);
            if (period_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_pv", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("period", period, e.per);
                    check("high_time", high_time, e.hi);
                    check("period_err", period_err, e.err);
                    check("locked_on_pv", locked, e.lck);
                end
            end
            prev_pv = period_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        ledpin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_pv", period_valid, 0);
        check("rst_err", period_err, 0);
        check("rst_locked", locked, 0);
        check("rst_stuck", stuck, 0);
        check("rst_level", stuck_level, 0);
        rst = 1'b0;

        // idle with no rise beyond counter saturation: never stuck
        repeat (300) @(negedge clk);
        check("idle_stuck", stuck, 0);
        check("idle_level", stuck_level, 0);

        // nominal wave locks on the 4th rise
        repeat (5) drive_wave(10, 10, 0, 1'b0);
        check("lock_nominal", locked, 1);

        // one long period breaks lock, then relock
        drive_wave(10, 15, 0, 1'b0);
        repeat (4) drive_wave(10, 10, 0, 1'b0);
        check("relock", locked, 1);

        // tolerance boundaries
        drive_wave(9, 9, 0, 1'b0);
        drive_wave(9, 13, 0, 1'b0);
        drive_wave(9, 8, 0, 1'b0);
        drive_wave(9, 14, 0, 1'b0);
        repeat (4) drive_wave(10, 10, 0, 1'b0);
        check("lock_after_tol", locked, 1);

        // stuck low after lock
        drive_wave(10, 60, 52, 1'b0);
        repeat (4) drive_wave(10, 10, 0, 1'b0);
        check("lock_after_stuck_lo", locked, 1);

        // stuck high after lock
        drive_wave(60, 10, 52, 1'b1);
        repeat (4) drive_wave(10, 10, 0, 1'b0);
        check("lock_after_stuck_hi", locked, 1);
        check("queue_before_rst", sb.size(), 0);

        // asynchronous reset between edges while locked
        ledpin = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check("arst_period", period, 0);
        check("arst_high", high_time, 0);
        check("arst_pv", period_valid, 0);
        check("arst_err", period_err, 0);
        check("arst_locked", locked, 0);
        check("arst_stuck", stuck, 0);
        check("arst_level", stuck_level, 0);
        ledpin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) drive_wave(10, 10, 0, 1'b0);
        check("lock_after_rst", locked, 1);

        repeat (5) @(negedge clk);
        check("queue_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
